// File: rtl/tt_um_serial_adder_yoda_pkg.sv
// Shared constants for the bit-serial adder: width, FSM encoding and pad bit positions.
package tt_um_serial_adder_yoda_pkg;

  // Operand/result width; fixed by the 8-bit pad interface.
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CntW  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // uio_in control bit positions
  localparam int unsigned UioLoadA = 0;
  localparam int unsigned UioLoadB = 1;
  localparam int unsigned UioStart = 2;
  localparam int unsigned UioCin   = 3;

  // uio_out status bit positions
  localparam int unsigned UioCout  = 5;
  localparam int unsigned UioBusy  = 6;
  localparam int unsigned UioDone  = 7;

  // Only the three status bits are driven out.
  localparam logic [7:0] UioOeMask = 8'b1110_0000;

endpackage

// File: rtl/tt_um_serial_adder_yoda_fa_cell.sv
// Gate-level full adder used as the single arithmetic cell of the serial adder.
module tt_um_serial_adder_yoda_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic axb;

  assign axb    = a_i ^ b_i;
  assign sum_o  = axb ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & axb);

endmodule

// File: rtl/tt_um_serial_adder_yoda.sv
// Bit-serial 8-bit adder: load A/B, start, shift LSB-first through one full adder for
// WIDTH cycles, then publish sum in R and carry-out in cout_r.
module tt_um_serial_adder_yoda
  import tt_um_serial_adder_yoda_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic load_a, load_b, start, cin;
  logic fa_sum, fa_cout;
  logic last_bit;
  logic unused;

  assign load_a   = uio_in[UioLoadA];
  assign load_b   = uio_in[UioLoadB];
  assign start    = uio_in[UioStart];
  assign cin      = uio_in[UioCin];
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign unused   = ^{ena, uio_in[7:4]};

  tt_um_serial_adder_yoda_fa_cell u_fa_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_sum),
    .cout_o(fa_cout)
  );

  // State and datapath registers; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture in idle, one shift/add step per run cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    r_d     = r_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (load_a) a_d = ui_in;
        if (load_b) b_d = ui_in;
        if (start) begin
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      StRun: begin
        s_d     = {fa_sum, s_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        // Publish including the bit produced this cycle.
        if (last_bit) begin
          r_d    = {fa_sum, s_q[WIDTH-1:1]};
          cout_d = fa_cout;
        end
      end
      default: ;
    endcase
  end

  // Pad outputs decoded from state and result registers.
  always_comb begin
    uo_out           = r_q;
    uio_out          = '0;
    uio_out[UioDone] = (state_q == StDone);
    uio_out[UioBusy] = (state_q == StRun);
    uio_out[UioCout] = cout_q;
    uio_oe           = UioOeMask;
  end

endmodule

// File: tb/tb_tt_um_serial_adder_yoda.sv
// Directed bench for the bit-serial adder with hand-computed sums.
module tb_tt_um_serial_adder_yoda;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;
  logic [7:0] prev_r;

  tt_um_serial_adder_yoda dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = 8'h01;
    step();
    ui_in  = b;
    uio_in = 8'h02;
    step();
    uio_in = 8'h00;
  endtask

  // Full operation; optionally toggles load_a/cin with ui_in=0 while running.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input bit disturb,
                       input logic [7:0] exp_r, input logic exp_co);
    int busy_n;
    load_ops(a, b);
    uio_in = {4'b0, cin, 3'b100};
    step();
    uio_in = 8'h00;
    ui_in  = 8'h00;
    check_eq({tag, "_r_held_in_run"}, uo_out, prev_r);
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (uio_out[7]) break;
      if (uio_out[6]) busy_n++;
      if (disturb) uio_in = {4'b0, i[0], 3'b001};
      step();
    end
    uio_in = 8'h00;
    check_eq({tag, "_busy_cycles"}, busy_n, 8);
    check_eq({tag, "_done"}, uio_out[7], 1'b1);
    check_eq({tag, "_sum"}, uo_out, exp_r);
    check_eq({tag, "_cout"}, uio_out[5], exp_co);
    step();
    check_eq({tag, "_idle_after"}, uio_out[7:6], 2'b00);
    check_eq({tag, "_r_held_idle"}, uo_out, exp_r);
    prev_r = exp_r;
  endtask

  initial begin
    int busy_n;
    int rises;
    logic prev_done;
    checks   = 0;
    failures = 0;
    prev_r   = 8'h00;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    rst_n    = 1'b0;
    step();
    step();
    check_eq("rst_uo_out", uo_out, 8'h00);
    check_eq("rst_uio_out", uio_out, 8'h00);
    check_eq("rst_uio_oe", uio_oe, 8'hE0);
    rst_n = 1'b1;
    step();

    do_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    do_op("disturb", 8'h5A, 8'h33, 1'b0, 1'b1, 8'h8D, 1'b0);
    do_op("add_0f_01_c", 8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0);

    // Start held high: one operation only, done holds until start drops.
    load_ops(8'h12, 8'h34);
    uio_in    = 8'h04;
    busy_n    = 0;
    rises     = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (uio_out[6]) busy_n++;
      if (uio_out[7] && !prev_done) rises++;
      prev_done = uio_out[7];
    end
    check_eq("hold_busy_cycles", busy_n, 8);
    check_eq("hold_done_rises", rises, 1);
    check_eq("hold_done_still", uio_out[7], 1'b1);
    check_eq("hold_sum", uo_out, 8'h46);
    uio_in = 8'h00;
    step();
    check_eq("hold_exit_idle", uio_out[7:6], 2'b00);
    prev_r = 8'h46;

    // Reset on the fourth RUN cycle aborts the operation.
    load_ops(8'h5A, 8'h33);
    uio_in = 8'h04;
    step();
    uio_in = 8'h00;
    step();
    step();
    step();
    check_eq("abort_busy_before", uio_out[6], 1'b1);
    rst_n = 1'b0;
    step();
    check_eq("abort_uo_out", uo_out, 8'h00);
    check_eq("abort_uio_out", uio_out, 8'h00);
    rst_n  = 1'b1;
    prev_r = 8'h00;
    step();
    step();
    check_eq("abort_no_restart", uio_out[7:6], 2'b00);
    do_op("after_abort", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);

    // Load A in the same cycle as start; the new operand must be used.
    load_ops(8'hEE, 8'h01);
    ui_in  = 8'h10;
    uio_in = 8'h05;
    step();
    uio_in = 8'h00;
    ui_in  = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (uio_out[7]) break;
      step();
    end
    check_eq("load_start_done", uio_out[7], 1'b1);
    check_eq("load_start_sum", uo_out, 8'h11);
    check_eq("load_start_cout", uio_out[5], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
